// File: rtl/jtbubl_comm_arb.sv
// Comm RAM arbiter: lets the main (A) and sub (B) Z80s share one single-port
// RAM. One CPU is granted at a time; the other is stretched through wait_n.
// Read data is captured per CPU at the end of the setup phase and held until
// the next grant of that CPU.
module jtbubl_comm_arb #(
    parameter int AW     = 13,
    parameter int DW     = 8,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    // main CPU
    input  logic          a_cs,
    input  logic          a_wrn,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_dout,
    output logic [DW-1:0] a_din,
    output logic          a_wait_n,
    // sub CPU
    input  logic          b_cs,
    input  logic          b_wrn,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_dout,
    output logic [DW-1:0] b_din,
    output logic          b_wait_n,
    // RAM side
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    output logic          ram_we,
    input  logic [DW-1:0] ram_q,
    // debug
    output logic [7:0]    conflicts
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        A_SETUP = 3'd1,
        A_DONE  = 3'd2,
        B_SETUP = 3'd3,
        B_DONE  = 3'd4
    } state_t;

    // Setup counter only needs to reach RD_LAT-1 (RD_LAT is 1..3)
    localparam int            CW       = 2;
    localparam logic [CW-1:0] LAST_CNT = CW'(RD_LAT - 1);

    state_t        state_reg, state_next;
    logic          pri_reg, pri_next;       // 0: A wins the next tie, 1: B wins
    logic [CW-1:0] cnt_reg, cnt_next;       // cycles spent in the current SETUP
    logic          wr_done_reg, wr_done_next; // write already issued for this grant
    logic          ram_we_reg, ram_we_next;
    logic [DW-1:0] a_din_reg, b_din_reg;
    logic [7:0]    conf_reg;

    logic enter_a, enter_b;   // grant starts this edge
    logic cap_a, cap_b;       // last SETUP edge: capture ram_q
    logic conf_inc;           // contended grant happens this edge
    logic on_a, on_b;         // side currently owning the RAM

    assign on_a = (state_reg == A_SETUP) || (state_reg == A_DONE);
    assign on_b = (state_reg == B_SETUP) || (state_reg == B_DONE);

    // Next-state: grant selection, setup timing, release and abort handover
    always_comb begin
        state_next = state_reg;
        pri_next   = pri_reg;
        cnt_next   = cnt_reg;
        enter_a    = 1'b0;
        enter_b    = 1'b0;
        cap_a      = 1'b0;
        cap_b      = 1'b0;
        conf_inc   = 1'b0;
        case (state_reg)
            IDLE: begin
                // Round robin only matters on a tie; any grant from IDLE
                // hands the next tie to the other side.
                if (a_cs && (!b_cs || !pri_reg)) begin
                    enter_a  = 1'b1;
                    pri_next = 1'b1;
                    conf_inc = b_cs;
                end else if (b_cs) begin
                    enter_b  = 1'b1;
                    pri_next = 1'b0;
                    conf_inc = a_cs;
                end
            end
            A_SETUP: begin
                if (!a_cs) begin
                    // CPU went away mid-access: abort without touching a_din
                    if (b_cs) enter_b = 1'b1;
                    else      state_next = IDLE;
                end else if (cnt_reg == LAST_CNT) begin
                    cap_a      = 1'b1;
                    state_next = A_DONE;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            A_DONE: begin
                if (!a_cs) begin
                    // Release goes straight to a waiting B, no idle bubble
                    if (b_cs) begin
                        enter_b  = 1'b1;
                        conf_inc = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            B_SETUP: begin
                if (!b_cs) begin
                    if (a_cs) enter_a = 1'b1;
                    else      state_next = IDLE;
                end else if (cnt_reg == LAST_CNT) begin
                    cap_b      = 1'b1;
                    state_next = B_DONE;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            B_DONE: begin
                if (!b_cs) begin
                    if (a_cs) begin
                        enter_a  = 1'b1;
                        conf_inc = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
        if (enter_a) begin
            state_next = A_SETUP;
            cnt_next   = '0;
        end
        if (enter_b) begin
            state_next = B_SETUP;
            cnt_next   = '0;
        end
    end

    // Write pulse: one per grant, either at grant time or on the late wr_n fall
    always_comb begin
        ram_we_next  = 1'b0;
        wr_done_next = wr_done_reg;
        if (enter_a) begin
            ram_we_next  = !a_wrn;
            wr_done_next = !a_wrn;
        end else if (enter_b) begin
            ram_we_next  = !b_wrn;
            wr_done_next = !b_wrn;
        end else if (on_a && a_cs && !a_wrn && !wr_done_reg) begin
            // cs still high, so the grant is kept while the pulse is out
            ram_we_next  = 1'b1;
            wr_done_next = 1'b1;
        end else if (on_b && b_cs && !b_wrn && !wr_done_reg) begin
            ram_we_next  = 1'b1;
            wr_done_next = 1'b1;
        end
    end

    // Arbiter state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            pri_reg     <= 1'b0;
            cnt_reg     <= '0;
            wr_done_reg <= 1'b0;
            ram_we_reg  <= 1'b0;
        end else begin
            state_reg   <= state_next;
            pri_reg     <= pri_next;
            cnt_reg     <= cnt_next;
            wr_done_reg <= wr_done_next;
            ram_we_reg  <= ram_we_next;
        end
    end

    // Per-CPU read data, loaded only on the last SETUP edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_din_reg <= '0;
            b_din_reg <= '0;
        end else begin
            if (cap_a) a_din_reg <= ram_q;
            if (cap_b) b_din_reg <= ram_q;
        end
    end

    // Saturating contention counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conf_reg <= '0;
        end else if (conf_inc && conf_reg != 8'hFF) begin
            conf_reg <= conf_reg + 8'd1;
        end
    end

    // RAM mux select comes from the state register only; IDLE parks on A
    assign ram_addr  = on_b ? b_addr : a_addr;
    assign ram_din   = on_b ? b_dout : a_dout;
    assign ram_we    = ram_we_reg;

    assign a_din     = a_din_reg;
    assign b_din     = b_din_reg;
    assign conflicts = conf_reg;

    // A selected CPU is held until its own DONE state; released during reset
    assign a_wait_n  = !rst_n || !(a_cs && state_reg != A_DONE);
    assign b_wait_n  = !rst_n || !(b_cs && state_reg != B_DONE);

endmodule
